siso_deser_collector: RTL and testbench

- Downstream stage of the 16-bit SISO FIFO shift register.
- Samples the shift register's serial Dout one bit per qualified cycle and reassembles 16-bit frames.
- Bit order follows the shift direction of the frame.
- Completed words are buffered in a small first-word-fall-through output FIFO with a valid/ready handshake toward the consumer.

---
 rtl/siso_deser_collector_if.sv | 23 ++
 rtl/siso_deser_collector.sv | 114 +++++++++++
 tb/tb_siso_deser_collector.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/siso_deser_collector_if.sv
// Serial-in and word-out handshake bundle for the SISO deserializer collector.
// The slave side is the collector, and the master side is the producer/consumer.
interface siso_deser_collector_if #(
   parameter int WIDTH = 16
);
   logic             load;
   logic             left;
   logic             bit_valid;
   logic             dout;
   logic [WIDTH-1:0] word;
   logic             word_valid;
   logic             word_ready;

   modport master (
      output load, left, bit_valid, dout, word_ready,
      input  word, word_valid
   );

   modport slave (
      input  load, left, bit_valid, dout, word_ready,
      output word, word_valid
   );
endinterface

// File: rtl/siso_deser_collector.sv
// Reassembles serial bits from the SISO shift register into WIDTH-bit frames.
// Completed frames are queued in a first-word-fall-through FIFO with valid/ready output.
module siso_deser_collector #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   siso_deser_collector_if.slave    bus,
   output logic                     busy,
   output logic [$clog2(WIDTH):0]   bit_count,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int PW = $clog2(DEPTH);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t           state;
   logic             dir;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] shifted;
   logic             push;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             pop;
   logic             full;
   logic             accept;

   // NOTE: combinational blocks use blocking '=' and assign every output on every path, so no latch can form.
   always_comb begin
      shifted = dir ? {acc[WIDTH-2:0], bus.dout} : {bus.dout, acc[WIDTH-1:1]};
      push    = (state == COLLECT) && !bus.load && bus.bit_valid
                && (bit_count == CW'(WIDTH - 1));
      pop     = (fifo_count != '0) && bus.word_ready;
      full    = (fifo_count == (PW + 1)'(DEPTH));
      accept  = push && (!full || pop);
   end

   // NOTE: sequential blocks use non-blocking '<=' so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         dir       <= 1'b0;
         acc       <= '0;
         bit_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.load) begin
                  state     <= COLLECT;
                  busy      <= 1'b1;
                  dir       <= bus.left;
                  acc       <= '0;
                  bit_count <= '0;
               end
            end
            COLLECT: begin
               // A restart wins over a bit arriving in the same cycle.
               if (bus.load) begin
                  dir       <= bus.left;
                  acc       <= '0;
                  bit_count <= '0;
               end else if (bus.bit_valid) begin
                  acc <= shifted;
                  if (push) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     bit_count <= '0;
                  end else begin
                     bit_count <= bit_count + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= shifted;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (push && !accept) overflow <= 1'b1;
      end
   end

   assign bus.word_valid = (fifo_count != '0);
   assign bus.word       = bus.word_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_siso_deser_collector.sv
// Directed and randomized bench for siso_deser_collector.
// Expected values come from a bit-list and word-queue model.
module tb_siso_deser_collector;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy;
   logic [$clog2(WIDTH):0] bit_count;
   logic [$clog2(DEPTH):0] fifo_count;
   logic overflow;

   siso_deser_collector_if #(.WIDTH(WIDTH)) bus ();

   siso_deser_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .busy       (busy),
      .bit_count  (bit_count),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: frame bits as a list, output FIFO as a word queue.
   bit               m_busy = 1'b0;
   bit               m_dir  = 1'b0;
   bit               m_ovf  = 1'b0;
   bit               bits_q[$];
   logic [WIDTH-1:0] fifo_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] assemble(input bit msb_first);
      logic [WIDTH-1:0] w = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (msb_first) w[WIDTH-1-i] = bits_q[i];
         else           w[i]         = bits_q[i];
      end
      return w;
   endfunction

   task automatic model_update(input bit r, ld, lf, bv, d, rdy);
      bit               do_pop;
      bit               do_push = 1'b0;
      logic [WIDTH-1:0] new_word = '0;
      if (r) begin
         m_busy = 1'b0;
         m_dir  = 1'b0;
         m_ovf  = 1'b0;
         bits_q.delete();
         fifo_q.delete();
         return;
      end
      do_pop = (fifo_q.size() > 0) && rdy;
      if (ld) begin
         m_busy = 1'b1;
         m_dir  = lf;
         bits_q.delete();
      end else if (m_busy && bv) begin
         bits_q.push_back(d);
         if (bits_q.size() == WIDTH) begin
            new_word = assemble(m_dir);
            do_push  = 1'b1;
            bits_q.delete();
            m_busy   = 1'b0;
         end
      end
      if (do_pop) void'(fifo_q.pop_front());
      if (do_push) begin
         if (fifo_q.size() < DEPTH) fifo_q.push_back(new_word);
         else                       m_ovf = 1'b1;
      end
   endtask

   task automatic compare_all();
      check("word",       32'(bus.word),   fifo_q.size() > 0 ? 32'(fifo_q[0]) : 32'h0);
      check("word_valid", 32'(bus.word_valid), 32'(fifo_q.size() > 0));
      check("fifo_count", 32'(fifo_count), 32'(fifo_q.size()));
      check("overflow",   32'(overflow),   32'(m_ovf));
      check("busy",       32'(busy),       32'(m_busy));
      check("bit_count",  32'(bit_count),  32'(bits_q.size()));
   endtask

   task automatic step(input bit r, ld, lf, bv, d, rdy);
      rst            = r;
      bus.load       = ld;
      bus.left       = lf;
      bus.bit_valid  = bv;
      bus.dout       = d;
      bus.word_ready = rdy;
      @(posedge clk);
      model_update(r, ld, lf, bv, d, rdy);
      #1;
      compare_all();
   endtask

   task automatic idle(input bit rdy);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), rdy);
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] v, input bit lf, input bit rdy_body, input bit rdy_last);
      step(1'b0, 1'b1, lf, 1'b0, 1'b0, rdy_body);
      for (int i = 0; i < WIDTH; i++) begin
         while ($urandom_range(0, 2) == 0) idle(rdy_body);
         step(1'b0, 1'b0, 1'b0, 1'b1, lf ? v[WIDTH-1-i] : v[i],
              (i == WIDTH - 1) ? rdy_last : rdy_body);
      end
   endtask

   initial begin
      bus.load = 1'b0; bus.left = 1'b0; bus.bit_valid = 1'b0;
      bus.dout = 1'b0; bus.word_ready = 1'b0;

      // Reset state
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check("rst_word_valid", 32'(bus.word_valid), 32'h0);
      check("rst_word", 32'(bus.word), 32'h0);

      // Reset mid-frame
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check("mid_bit_count", 32'(bit_count), 32'd7);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("mid_busy", 32'(busy), 32'h0);
      check("mid_bit_count0", 32'(bit_count), 32'h0);
      check("mid_fifo_count", 32'(fifo_count), 32'h0);
      check("mid_overflow", 32'(overflow), 32'h0);

      // Bit_Valid ignored while idle
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("idle_bit_count", 32'(bit_count), 32'h0);

      // MSB-first frame, consumer always ready
      send_frame(16'hA5C3, 1'b1, 1'b1, 1'b1);
      check("msb_word", 32'(bus.word), 32'hA5C3);
      check("msb_valid", 32'(bus.word_valid), 32'h1);
      check("msb_busy", 32'(busy), 32'h0);
      idle(1'b1);
      check("msb_one_cycle", 32'(bus.word_valid), 32'h0);

      // LSB-first frame
      send_frame(16'h1234, 1'b0, 1'b1, 1'b1);
      check("lsb_word", 32'(bus.word), 32'h1234);
      idle(1'b1);

      // Restart with Load and Bit_Valid together
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("restart_bit_count", 32'(bit_count), 32'h0);
      for (int i = 0; i < WIDTH; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("restart_count", 32'(fifo_count), 32'h1);
      check("restart_word", 32'(bus.word), 32'hFFFF);
      idle(1'b1);

      // Fill past capacity
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int f = 1; f <= 5; f++) send_frame(16'(f), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      check("full_count", 32'(fifo_count), 32'd4);
      check("full_overflow", 32'(overflow), 32'h1);
      for (int f = 1; f <= 4; f++) begin
         check("drain_word", 32'(bus.word), 32'(f));
         idle(1'b1);
      end
      check("drain_empty", 32'(bus.word_valid), 32'h0);
      check("drain_ovf_sticky", 32'(overflow), 32'h1);

      // Push and pop on the same edge while full
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int f = 0; f < 4; f++) send_frame(16'h0011 + 16'(f), 1'b1, 1'b0, 1'b0);
      send_frame(16'h0015, 1'b0, 1'b0, 1'b1);
      check("pp_count", 32'(fifo_count), 32'd4);
      check("pp_overflow", 32'(overflow), 32'h0);
      for (int f = 2; f <= 5; f++) begin
         check("pp_drain", 32'(bus.word), 32'h0010 + 32'(f));
         idle(1'b1);
      end
      check("pp_empty", 32'(bus.word_valid), 32'h0);

      // Randomized traffic against the model
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 1500; n++) begin
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 24) == 0,
              1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)),
              $urandom_range(0, 3) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
